// File: rtl/asin_sar.sv
// asin_sar: successive-approximation inverse of the quarter-wave sine table.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready, y  8-bit sign-magnitude sample in
//   out_valid/out_ready, x  10-bit phase code {sign,1'b0,addr} out

// sin_fragment: quarter-wave sine magnitude table, 8-bit addr -> 7-bit mag.
// Parabolic fit 127*b*(512-b)/2^16 with b=addr+1; monotonic, 0..127.
module sin_fragment (
  input  logic [7:0] addr,
  output logic [6:0] mag
);

  logic [8:0]  b;
  logic [8:0]  c;
  logic [23:0] p;

  assign b   = {1'b0, addr} + 9'd1;
  assign c   = 9'd511 - {1'b0, addr};
  assign p   = 24'(b) * 24'(c) * 24'd127;
  assign mag = 7'(p >> 16);

endmodule

module asin_sar (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] x
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t     state;
  logic       sign;
  logic [6:0] m;
  logic [7:0] acc;
  logic [2:0] k;

  logic [7:0] trial;
  logic [7:0] acc_next;
  logic [6:0] mag;

  // Try setting bit k; keep it if the table value still fits under m.
  assign trial    = acc | (8'd1 << k);
  assign acc_next = (mag <= m) ? trial : acc;
  assign in_ready = (state == IDLE);

  sin_fragment u_tab (
    .addr (trial),
    .mag  (mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      x         <= 10'h000;
      acc       <= 8'h00;
      k         <= 3'd7;
      sign      <= 1'b0;
      m         <= 7'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= y[7];
            m     <= y[6:0];
            acc   <= 8'h00;
            k     <= 3'd7;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          acc <= acc_next;
          if (k == 3'd0) begin
            x         <= {sign, 1'b0, acc_next};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
